// File: rtl/result_writer_pkg.sv
// Shared types and constants for the ray-result write path to SDRAM.
// Holds the writer state encoding, Avalon halfword sizing and Q16.16 helpers.
package result_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  localparam int unsigned AVM_HALF_BYTES = 2;
  localparam int unsigned RESULT_NDWORDS = 3;

  // Q16.16 fixed-point unity and largest positive value
  localparam logic [31:0] FIP_ONE = 32'h0001_0000;
  localparam logic [31:0] FIP_MAX = 32'h7FFF_FFFF;

  // Byte address of record 'index'; product and sum both wrap modulo 2^32.
  function automatic logic [31:0] record_addr(input logic [31:0] base,
                                              input logic [31:0] index,
                                              input int unsigned ndwords);
    logic [31:0] stride;
    stride = 32'(ndwords * 2 * AVM_HALF_BYTES);
    return base + index * stride;
  endfunction

endpackage

// File: rtl/result_writer.sv
// Avalon-MM write master that serialises one per-ray result record into
// 2*NDWORDS little-endian 16-bit writes, honouring waitrequest.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int unsigned NDWORDS = RESULT_NDWORDS
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [31:0]             i_baseaddr,
  input  logic [31:0]             i_index,
  input  logic [32*NDWORDS-1:0]   i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    avm_m0_write,
  output logic [31:0]             avm_m0_address,
  output logic [15:0]             avm_m0_writedata,
  output logic [1:0]              avm_m0_byteenable,
  input  logic                    avm_m0_waitrequest
);

  localparam int unsigned NHALF  = 2 * NDWORDS;
  localparam int unsigned HW     = (NHALF > 2) ? $clog2(NHALF) : 1;
  localparam logic [HW-1:0] LAST_H = HW'(NHALF - 1);

  wr_state_e             state_q;
  logic [HW-1:0]         h_q;
  logic [32*NDWORDS-1:0] data_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  write_q;
  logic [31:0]           addr_q;
  logic [15:0]           wdata_q;
  logic [1:0]            be_q;

  logic                  accept;
  logic                  last_h;
  logic [HW-1:0]         h_d;
  logic [15:0]           next_half;
  logic [31:0]           start_addr;

  always_comb begin
    // NOTE: every signal gets a value before any conditional, so no latch can be inferred.
    accept     = (state_q == ST_IDLE) && i_valid && ready_q;
    last_h     = (h_q == LAST_H);
    h_d        = h_q + HW'(1);
    next_half  = '0;
    start_addr = record_addr(i_baseaddr, i_index, NDWORDS);
    if (!last_h) begin
      next_half = data_q[int'(h_d) * 16 +: 16];
    end
  end

  // Address advances by one halfword per accepted beat, equal to A0 + 2*h.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      // NOTE: the record buffer is a plain register bank, so it is cleared with the rest of the state.
      state_q <= ST_IDLE;
      h_q     <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= i_data;
            h_q     <= '0;
            addr_q  <= start_addr;
            wdata_q <= i_data[15:0];
            write_q <= 1'b1;
            be_q    <= 2'b11;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (write_q && !avm_m0_waitrequest) begin
            if (last_h) begin
              write_q <= 1'b0;
              be_q    <= 2'b00;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              h_q     <= h_d;
              addr_q  <= addr_q + 32'(AVM_HALF_BYTES);
              wdata_q <= next_half;
            end
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: begin
          write_q <= 1'b0;
          be_q    <= 2'b00;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready           = ready_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign avm_m0_write      = write_q;
  assign avm_m0_address    = addr_q;
  assign avm_m0_writedata  = wdata_q;
  assign avm_m0_byteenable = be_q;

endmodule
